// File: rtl/tmds_std_dec.sv
// tmds_std_dec: TMDS receive decoder with control-token word alignment.
// Bit-slips through ten offsets until tokens lock, then decodes symbols.
module tmds_std_dec #(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 64,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] din,
    input  logic       din_valid,
    output logic [7:0] dout,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic       out_valid,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic [7:0] slip_cnt
);

    localparam int SW = $clog2(SEARCH_TIMEOUT);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int IW = $clog2(LOSS_TIMEOUT);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  prev_din_q, prev_din_d;
    logic [9:0]  a_word_q, a_word_d;
    logic        a_hit_q, a_hit_d;
    logic [1:0]  a_tok_q, a_tok_d;
    logic        a_valid_q, a_valid_d;
    logic [7:0]  dout_q, dout_d;
    logic        de_q, de_d;
    logic        c0_q, c0_d;
    logic        c1_q, c1_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  bit_offset_q, bit_offset_d;
    logic [7:0]  slip_cnt_q, slip_cnt_d;
    logic [SW-1:0] search_cnt_q, search_cnt_d;
    logic [RW-1:0] ctrl_run_q, ctrl_run_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    logic [9:0]  w;
    logic        hit;
    logic [1:0]  tok;
    logic [7:0]  q;
    logic [7:0]  data_byte;
    logic [RW-1:0] run_inc;

    // aligned word: 10 bits of {din, prev_din} starting at the current offset
    assign w = 10'({din, prev_din_q} >> bit_offset_q);

    // match the aligned word against the four control tokens
    always_comb begin
        hit = 1'b1;
        tok = 2'b00;
        unique case (w)
            10'b1101010100: tok = 2'b00;
            10'b0010101011: tok = 2'b01;
            10'b0101010100: tok = 2'b10;
            10'b1010101011: tok = 2'b11;
            default:        hit = 1'b0;
        endcase
    end

    // undo the transition-minimising and DC-balance stages of the encoder
    always_comb begin
        q = a_word_q[9] ? ~a_word_q[7:0] : a_word_q[7:0];
        data_byte[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            data_byte[i] = a_word_q[8] ? (q[i] ^ q[i-1])
                                       : ~(q[i] ^ q[i-1]);
        end
    end

    // next-state: window, two pipeline stages and the alignment FSM
    always_comb begin
        state_d      = state_q;
        prev_din_d   = prev_din_q;
        a_word_d     = a_word_q;
        a_hit_d      = a_hit_q;
        a_tok_d      = a_tok_q;
        a_valid_d    = a_valid_q;
        dout_d       = dout_q;
        de_d         = de_q;
        c0_d         = c0_q;
        c1_d         = c1_q;
        out_valid_d  = 1'b0;
        bit_offset_d = bit_offset_q;
        slip_cnt_d   = slip_cnt_q;
        search_cnt_d = search_cnt_q;
        ctrl_run_d   = ctrl_run_q;
        idle_cnt_d   = idle_cnt_q;
        run_inc      = hit ? ctrl_run_q + 1'b1 : '0;
        if (din_valid) begin
            prev_din_d = din;
            a_word_d   = w;
            a_hit_d    = hit;
            a_tok_d    = tok;
            a_valid_d  = 1'b1;
            if (a_valid_q) begin
                if (a_hit_q) begin
                    de_d   = 1'b0;
                    dout_d = 8'h00;
                    c1_d   = a_tok_q[1];
                    c0_d   = a_tok_q[0];
                end else begin
                    de_d   = 1'b1;
                    dout_d = data_byte;
                end
            end
            unique case (state_q)
                ST_SEARCH: begin
                    search_cnt_d = search_cnt_q + 1'b1;
                    ctrl_run_d   = run_inc;
                    if (run_inc == RW'(LOCK_COUNT)) begin
                        state_d      = ST_LOCKED;
                        idle_cnt_d   = '0;
                        search_cnt_d = '0;
                        ctrl_run_d   = '0;
                    end else if (search_cnt_q == SW'(SEARCH_TIMEOUT - 1)) begin
                        bit_offset_d = (bit_offset_q == 4'd9) ? 4'd0
                                                              : bit_offset_q + 4'd1;
                        search_cnt_d = '0;
                        ctrl_run_d   = '0;
                        if (slip_cnt_q != 8'hff) begin
                            slip_cnt_d = slip_cnt_q + 8'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (hit) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IW'(LOSS_TIMEOUT - 1)) begin
                        state_d      = ST_SEARCH;
                        idle_cnt_d   = '0;
                        search_cnt_d = '0;
                        ctrl_run_d   = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
            out_valid_d = a_valid_q && (state_d == ST_LOCKED);
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SEARCH;
            prev_din_q   <= '0;
            a_word_q     <= '0;
            a_hit_q      <= 1'b0;
            a_tok_q      <= '0;
            a_valid_q    <= 1'b0;
            dout_q       <= '0;
            de_q         <= 1'b0;
            c0_q         <= 1'b0;
            c1_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            bit_offset_q <= '0;
            slip_cnt_q   <= '0;
            search_cnt_q <= '0;
            ctrl_run_q   <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_din_q   <= prev_din_d;
            a_word_q     <= a_word_d;
            a_hit_q      <= a_hit_d;
            a_tok_q      <= a_tok_d;
            a_valid_q    <= a_valid_d;
            dout_q       <= dout_d;
            de_q         <= de_d;
            c0_q         <= c0_d;
            c1_q         <= c1_d;
            out_valid_q  <= out_valid_d;
            bit_offset_q <= bit_offset_d;
            slip_cnt_q   <= slip_cnt_d;
            search_cnt_q <= search_cnt_d;
            ctrl_run_q   <= ctrl_run_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign de         = de_q;
    assign c0         = c0_q;
    assign c1         = c1_q;
    assign out_valid  = out_valid_q;
    assign locked     = (state_q == ST_LOCKED);
    assign bit_offset = bit_offset_q;
    assign slip_cnt   = slip_cnt_q;

endmodule
